// File: rtl/bmf_block_normalizer.sv
// bmf_block_normalizer
// Buffers one block of minifloat products tagged with a 2-bit exponent
// overflow, tracks the largest overflow as the shared block exponent, then
// drains the block through the normalize stage against that exponent.
// Ports:
//   clk, rst                         clock, asynchronous active-high reset
//   in_valid/in_ready/in_data/in_last   product stream {ovf, sign, exp, sig}
//   out_valid/out_ready/out_data        normalized stream {sign, exp, sig}
//   out_blk_exp                      shared block exponent of current block
//   out_last                         final word of the block
module bmf_block_normalizer #(
    parameter int unsigned NEXP = 2,
    parameter int unsigned NSIG = 5,
    parameter int unsigned BLK  = 8
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     in_valid,
    output logic                     in_ready,
    input  logic [2*NEXP+NSIG:0]     in_data,
    input  logic                     in_last,
    output logic                     out_valid,
    input  logic                     out_ready,
    output logic [NEXP+NSIG:0]       out_data,
    output logic [NEXP-1:0]          out_blk_exp,
    output logic                     out_last
);

    localparam int unsigned DW = 1 + NEXP + NSIG;
    localparam int unsigned IW = 2 * NEXP + NSIG + 1;
    localparam int unsigned AW = $clog2(BLK);
    localparam int unsigned LW = AW + 1;

    typedef enum logic {FILL, DRAIN} state_t;

    state_t          state, state_nxt;
    logic [AW-1:0]   wr_cnt, wr_nxt;
    logic [AW-1:0]   rd_cnt, rd_nxt;
    logic [LW-1:0]   len, len_nxt;
    logic [NEXP-1:0] blk_max, max_nxt;
    logic [IW-1:0]   mem [BLK];

    logic            in_fire;
    logic            out_fire;
    logic [IW-1:0]   rd_entry;
    logic            ready_nxt;
    logic            valid_nxt;
    logic [DW-1:0]   data_nxt;
    logic [NEXP-1:0] bexp_nxt;
    logic            last_nxt;

    // Align one product to the block exponent: shift out the exponent deficit,
    // dropping into the subnormal range when the exponent runs out.
    function automatic logic [DW-1:0] normalize(input logic [IW-1:0] ent,
                                                input logic [NEXP-1:0] bmax);
        logic [NEXP-1:0] ovf, ex, diff, shamt, exo;
        logic            sgn;
        logic [NSIG-1:0] sig, sigo;
        {ovf, sgn, ex, sig} = ent;
        diff = bmax - ovf;
        if (diff >= ex) begin
            exo   = '0;
            shamt = diff - ex;
            sigo  = (32'(shamt) >= NSIG) ? '0 : (sig >> shamt);
        end else begin
            exo   = ex - diff;
            sigo  = sig;
        end
        return {sgn, exo, sigo};
    endfunction

    assign in_fire  = in_valid && in_ready && (state == FILL);
    assign out_fire = out_valid && out_ready;

    // Product buffer; contents are don't-care until written in FILL.
    always_ff @(posedge clk) begin
        if (in_fire) mem[wr_cnt] <= in_data;
    end

    // Next-state, counters, and next output word.
    always_comb begin
        state_nxt = state;
        wr_nxt    = wr_cnt;
        rd_nxt    = rd_cnt;
        len_nxt   = len;
        max_nxt   = blk_max;
        rd_entry  = '0;
        ready_nxt = 1'b0;
        valid_nxt = 1'b0;
        data_nxt  = '0;
        bexp_nxt  = '0;
        last_nxt  = 1'b0;

        case (state)
            FILL: begin
                if (in_fire) begin
                    wr_nxt  = wr_cnt + AW'(1);
                    max_nxt = (wr_cnt == '0) ? in_data[IW-1 -: NEXP]
                            : ((in_data[IW-1 -: NEXP] > blk_max) ? in_data[IW-1 -: NEXP] : blk_max);
                    if (in_last || (wr_cnt == AW'(BLK - 1))) begin
                        state_nxt = DRAIN;
                        len_nxt   = LW'(wr_cnt) + LW'(1);
                        rd_nxt    = '0;
                    end
                end
            end
            DRAIN: begin
                if (out_fire) begin
                    if (LW'(rd_cnt) == len - LW'(1)) begin
                        state_nxt = FILL;
                        wr_nxt    = '0;
                        rd_nxt    = '0;
                        max_nxt   = '0;
                    end else begin
                        rd_nxt = rd_cnt + AW'(1);
                    end
                end
            end
            default: state_nxt = FILL;
        endcase

        // The final beat is written on the same edge that enters DRAIN, so
        // forward it when it is the first word to be presented.
        rd_entry  = (in_fire && (rd_nxt == wr_cnt)) ? in_data : mem[rd_nxt];
        ready_nxt = (state_nxt == FILL);
        valid_nxt = (state_nxt == DRAIN);
        if (valid_nxt) begin
            data_nxt = normalize(rd_entry, max_nxt);
            bexp_nxt = max_nxt;
            last_nxt = (LW'(rd_nxt) == len_nxt - LW'(1));
        end
    end

    // State and registered outputs.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state       <= FILL;
            wr_cnt      <= '0;
            rd_cnt      <= '0;
            len         <= '0;
            blk_max     <= '0;
            in_ready    <= 1'b0;
            out_valid   <= 1'b0;
            out_data    <= '0;
            out_blk_exp <= '0;
            out_last    <= 1'b0;
        end else begin
            state       <= state_nxt;
            wr_cnt      <= wr_nxt;
            rd_cnt      <= rd_nxt;
            len         <= len_nxt;
            blk_max     <= max_nxt;
            in_ready    <= ready_nxt;
            out_valid   <= valid_nxt;
            out_data    <= data_nxt;
            out_blk_exp <= bexp_nxt;
            out_last    <= last_nxt;
        end
    end

endmodule

// File: tb/tb_bmf_block_normalizer.sv
// Testbench for bmf_block_normalizer: directed and random blocks checked
// against a behavioural model of block-exponent normalization.
module tb_bmf_block_normalizer;

    localparam int unsigned NEXP = 2;
    localparam int unsigned NSIG = 5;
    localparam int unsigned BLK  = 8;

    logic       clk = 1'b0;
    logic       rst;
    logic       in_valid;
    logic       in_ready;
    logic [9:0] in_data;
    logic       in_last;
    logic       out_valid;
    logic       out_ready;
    logic [7:0] out_data;
    logic [1:0] out_blk_exp;
    logic       out_last;

    int tests = 0;
    int fails = 0;

    logic [9:0] ent [8];
    int         n;
    bit         mark_last;

    bmf_block_normalizer #(.NEXP(NEXP), .NSIG(NSIG), .BLK(BLK)) dut (
        .clk(clk), .rst(rst),
        .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data), .in_last(in_last),
        .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
        .out_blk_exp(out_blk_exp), .out_last(out_last)
    );

    always #5 clk = ~clk;

    // Expected output word for entry {ovf,s,e,sig} under block max mx.
    function automatic logic [7:0] ref_norm(input logic [9:0] e, input int mx);
        int ovf, ex, sg, diff, eo, so, sh;
        ovf  = int'(e[9:8]);
        ex   = int'(e[6:5]);
        sg   = int'(e[4:0]);
        diff = mx - ovf;
        if (diff >= ex) begin
            eo = 0;
            sh = diff - ex;
            so = (sh >= 5) ? 0 : sg / (1 << sh);
        end else begin
            eo = ex - diff;
            so = sg;
        end
        return {e[7], 2'(eo), 5'(so)};
    endfunction

    task automatic send_block();
        for (int i = 0; i < n; i++) begin
            bit acc = 0;
            int guard = 0;
            in_valid = 1'b1;
            in_data  = ent[i];
            in_last  = mark_last && (i == n - 1);
            while (!acc && guard < 100) begin
                acc = in_ready;
                @(posedge clk); #1;
                guard++;
            end
            in_valid = 1'b0;
            in_last  = 1'b0;
            tests++;
            if (!acc) begin
                fails++;
                $display("FAIL send_timeout beat=%0d got in_ready=0 want 1", i);
            end
            tests++;
            if (i == n - 1) begin
                if ({out_valid, in_ready} !== 2'b10) begin
                    fails++;
                    $display("FAIL block_close got {ov,ir}=%b want 10", {out_valid, in_ready});
                end
            end else if ({out_valid, in_ready} !== 2'b01) begin
                fails++;
                $display("FAIL early_close beat=%0d got {ov,ir}=%b want 01", i, {out_valid, in_ready});
            end
        end
    endtask

    task automatic drain_block(input bit bp, input bit noise);
        int         mx = 0;
        int         idx = 0;
        int         cyc = 0;
        bit         stall = 0;
        bit         rdy;
        logic [7:0] exp_w;
        logic [11:0] cur, held, want;
        held = '0;
        for (int i = 0; i < n; i++) if (int'(ent[i][9:8]) > mx) mx = int'(ent[i][9:8]);
        while (idx < n && cyc < 500) begin
            out_ready = bp ? 1'($urandom_range(0, 1)) : 1'b1;
            if (noise) begin
                in_valid = 1'b1;
                in_data  = 10'($urandom);
                in_last  = 1'($urandom_range(0, 1));
            end
            exp_w = ref_norm(ent[idx], mx);
            cur   = {out_valid, out_data, out_blk_exp, out_last};
            want  = {1'b1, exp_w, 2'(mx), 1'(idx == n - 1)};
            tests++;
            if ({cur, in_ready} !== {want, 1'b0}) begin
                fails++;
                $display("FAIL word%0d got {ov,data,bexp,last,ir}=%h want %h",
                         idx, {cur, in_ready}, {want, 1'b0});
            end
            if (stall) begin
                tests++;
                if (cur !== held) begin
                    fails++;
                    $display("FAIL hold word%0d got %h want %h", idx, cur, held);
                end
            end
            held  = cur;
            stall = !out_ready;
            rdy   = out_ready;
            @(posedge clk); #1;
            cyc++;
            if (rdy) idx++;
        end
        out_ready = 1'b0;
        in_valid  = 1'b0;
        in_last   = 1'b0;
        tests++;
        if (idx < n) begin
            fails++;
            $display("FAIL drain_timeout got %0d words want %0d", idx, n);
        end
        tests++;
        if ({out_valid, in_ready} !== 2'b01) begin
            fails++;
            $display("FAIL reopen got {ov,ir}=%b want 01", {out_valid, in_ready});
        end
    endtask

    task automatic test_reset();
        repeat (3) @(posedge clk);
        #1;
        tests++;
        if ({out_valid, out_data, out_blk_exp, out_last, in_ready} !== 13'd0) begin
            fails++;
            $display("FAIL reset_outputs got %h want 0",
                     {out_valid, out_data, out_blk_exp, out_last, in_ready});
        end
        rst = 1'b0;
        @(posedge clk); #1;
        tests++;
        if (in_ready !== 1'b1) begin
            fails++;
            $display("FAIL reset_release_ready got %b want 1", in_ready);
        end
    endtask

    task automatic test_pair();
        n = 2; mark_last = 1;
        ent[0] = {2'd0, 1'b0, 2'd1, 5'b10110};
        ent[1] = {2'd3, 1'b1, 2'd2, 5'b00111};
        send_block();
        tests++;
        if (out_data !== 8'b0_00_00101) begin
            fails++;
            $display("FAIL pair_word0 got %b want 00000101", out_data);
        end
        drain_block(0, 0);
    endtask

    task automatic test_full_block();
        n = 8; mark_last = 0;
        for (int i = 0; i < 8; i++)
            ent[i] = {2'd1, 1'($urandom), ((i == 2 || i == 5) ? 2'd0 : 2'(1 + (i % 3))), 5'($urandom)};
        send_block();
        drain_block(0, 0);
    endtask

    task automatic test_single_then_shift();
        n = 1; mark_last = 1;
        ent[0] = {2'd2, 1'b0, 2'd3, 5'b11111};
        send_block();
        drain_block(0, 0);
        n = 2; mark_last = 1;
        ent[0] = {2'd0, 1'b0, 2'd0, 5'b10000};
        ent[1] = {2'd3, 1'b1, 2'd1, 5'b01010};
        send_block();
        tests++;
        if (out_data !== 8'b0_00_00010) begin
            fails++;
            $display("FAIL shift3 got %b want 00000010", out_data);
        end
        drain_block(0, 0);
    endtask

    task automatic test_backpressure();
        n = 6; mark_last = 1;
        for (int i = 0; i < 6; i++) ent[i] = 10'($urandom);
        send_block();
        drain_block(1, 0);
    endtask

    task automatic test_ignore_during_drain();
        n = 5; mark_last = 1;
        for (int i = 0; i < 5; i++) ent[i] = 10'($urandom);
        send_block();
        drain_block(1, 1);
    endtask

    task automatic test_reset_mid_drain();
        n = 3; mark_last = 1;
        ent[0] = {2'd3, 1'b1, 2'd2, 5'b10101};
        ent[1] = {2'd1, 1'b0, 2'd3, 5'b11000};
        ent[2] = {2'd0, 1'b1, 2'd1, 5'b01111};
        send_block();
        out_ready = 1'b1;
        repeat (2) begin @(posedge clk); #1; end
        out_ready = 1'b0;
        tests++;
        if ({out_valid, out_last} !== 2'b11) begin
            fails++;
            $display("FAIL pre_reset_word2 got {ov,last}=%b want 11", {out_valid, out_last});
        end
        #2 rst = 1'b1;
        #1;
        tests++;
        if ({out_valid, out_data, out_blk_exp, out_last, in_ready} !== 13'd0) begin
            fails++;
            $display("FAIL async_reset got %h want 0",
                     {out_valid, out_data, out_blk_exp, out_last, in_ready});
        end
        @(posedge clk); #1;
        rst = 1'b0;
        @(posedge clk); #1;
        tests++;
        if ({out_valid, in_ready} !== 2'b01) begin
            fails++;
            $display("FAIL post_reset got {ov,ir}=%b want 01", {out_valid, in_ready});
        end
        n = 2; mark_last = 1;
        ent[0] = {2'd0, 1'b0, 2'd2, 5'b11011};
        ent[1] = {2'd1, 1'b1, 2'd0, 5'b10010};
        send_block();
        drain_block(0, 0);
    endtask

    task automatic test_random();
        for (int b = 0; b < 12; b++) begin
            n = $urandom_range(1, 8);
            mark_last = (n < 8) ? 1'b1 : 1'($urandom_range(0, 1));
            for (int i = 0; i < n; i++) ent[i] = 10'($urandom);
            send_block();
            drain_block(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
        end
    endtask

    initial begin
        rst       = 1'b1;
        in_valid  = 1'b0;
        in_data   = '0;
        in_last   = 1'b0;
        out_ready = 1'b0;
        test_reset();
        test_pair();
        test_full_block();
        test_single_then_shift();
        test_backpressure();
        test_ignore_during_drain();
        test_reset_mid_drain();
        test_random();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/bmf_block_normalizer.md
# bmf_block_normalizer

Block-level sequencer for the minifloat multiplier output path. It buffers one block of multiplier products, each tagged with its 2-bit exponent overflow, and tracks the largest overflow as the shared block exponent. It then drains the block through the normalize stage against that shared exponent, so every output word carries the common block exponent on a valid/ready stream. It sits between the fp_mult product array and the block-minifloat accumulator/writeback.

## Interface
- NEXP, 2, minifloat exponent width; also the width of the overflow tag and of the block exponent
- NSIG, 5, minifloat significand width; minifloat word is 1+NEXP+NSIG bits
- BLK, 8, maximum products per block; the buffer holds BLK entries, indices are clog2(BLK) bits
- clk  in  1  single clock, rising edge
- rst  in  1  asynchronous, active-high reset
- in_valid  in  1  product word valid
- in_ready  out  1  block accepts product
- in_data  in  2*NEXP+NSIG+1  {ovf[NEXP-1:0], sign, exp[NEXP-1:0], sig[NSIG-1:0]}
- in_last  in  1  final product of the block; qualified by in_valid
- out_valid  out  1  normalized word valid
- out_ready  in  1  downstream accepts
- out_data  out  1+NEXP+NSIG  {sign, exp, sig} normalized to the block exponent
- out_blk_exp  out  NEXP  shared block exponent (max ovf) of the current block
- out_last  out  1  final word of the block

## Operation
- States: FILL and DRAIN. Reset enters FILL.
- FILL:
  - in_ready=1.
  - On each in_valid&in_ready, write in_data to buf[wr_cnt] and increment wr_cnt.
  - Running max: blk_max <= (first beat) ? ovf : max(blk_max, ovf), unsigned compare.
  - The block ends on an accepted beat with in_last=1, or when wr_cnt==BLK-1. Either condition moves the state to DRAIN, latches len=wr_cnt+1, and sets rd_cnt=0.
- DRAIN:
  - in_ready=0; in_valid is ignored.
  - out_valid=1.
  - out_data = normalize(buf[rd_cnt], blk_max).
  - out_blk_exp=blk_max; out_last = (rd_cnt==len-1).
  - On out_valid&out_ready, increment rd_cnt. The last handshake returns the state to FILL and clears wr_cnt and blk_max.
- Normalize rule (NEXP-bit unsigned arithmetic). diff = blk_max - ovf; diff is always ≥0 because blk_max ≥ ovf.
  - If diff ≥ exp: exp_o=0 and sig_o = sig >> (diff-exp). A shift of NSIG or more yields 0.
  - Otherwise exp_o = exp-diff and sig_o = sig unchanged.
  - Sign passes through unchanged.
- While out_ready=0, all out_* signals hold stable.
- A block is never partially overwritten. There is no fill/drain overlap (single buffer).

## Timing
- Reset values:
  - state=FILL; wr_cnt, rd_cnt, len, blk_max = 0.
  - out_valid=0, out_data=0, out_blk_exp=0, out_last=0.
  - in_ready=0 while rst is asserted and 1 from the first cycle after deassertion.
- Output fields are driven from registered state (buffer, blk_max, rd_cnt) through the normalize logic. There is no combinational path from in_* to out_*.
- Latency: out_valid rises on the cycle after the final input handshake.
- Throughput with out_ready held at 1: one word per cycle; the block occupies len cycles in FILL and len cycles in DRAIN.
- in_ready falls on the cycle after the final input handshake. It rises on the cycle after the out_last handshake.
- in_last together with wr_cnt==BLK-1 is a single end condition with len=BLK.
- in_last on the first beat gives a block of length 1.
- Reset asserted mid-FILL or mid-DRAIN discards the block immediately. Outputs take their reset values asynchronously.

## Test plan
- NEXP=2, NSIG=5. Block [{ovf=0,s=0,e=1,sig=10110}, {ovf=3,s=1,e=2,sig=00111, last}] -> out_blk_exp=3 on both words; word0 = {0,00,00101}; word1 = {1,10,00111} with out_last=1.
- Eight beats, all ovf=1, no in_last -> the block closes at the 8th handshake. Outputs equal the inputs (diff=0, exp>0), except entries with exp=0, which keep exp=0 and are unshifted. out_last is set on word 7 only. in_ready=0 for the 8 drain cycles.
- Single beat {ovf=2,e=3,sig=11111,last}, then {ovf=0,e=0,sig=10000} in a second block that has a max of 3 -> block 1 outputs {e=3,sig=11111}. In block 2, diff=3 and shift=3 gives sig=00010.
- Backpressure: toggle out_ready 0/1 randomly during DRAIN -> out_* stable whenever out_ready=0, no word lost or duplicated, in_ready stays 0 until the final handshake.
- Assert rst after 2 of 3 drain handshakes -> all outputs go to their reset values asynchronously. After release, a new block is accepted with blk_max recomputed from zero.
- Hold in_valid=1 during DRAIN with changing in_data -> these beats are ignored. The drained block matches the original captures.
